inst_queue: RTL and testbench



---
 rtl/inst_queue_if.sv | 36 +++
 rtl/inst_queue.sv | 172 +++++++++++++++++
 tb/tb_inst_queue.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_queue_if.sv
// rtl/inst_queue_if.sv - AXI-Lite host bus bundle for the instruction queue
interface inst_queue_if #(
    parameter int ADDR_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] s_aw_addr;
    logic                  s_aw_valid;
    logic                  s_aw_ready;
    logic [31:0]           s_w_data;
    logic [3:0]            s_w_strb;
    logic                  s_w_valid;
    logic                  s_w_ready;
    logic [1:0]            s_b_resp;
    logic                  s_b_valid;
    logic                  s_b_ready;
    logic [ADDR_WIDTH-1:0] s_ar_addr;
    logic                  s_ar_valid;
    logic                  s_ar_ready;
    logic [31:0]           s_r_data;
    logic [1:0]            s_r_resp;
    logic                  s_r_valid;
    logic                  s_r_ready;

    modport master (
        output s_aw_addr, s_aw_valid, s_w_data, s_w_strb, s_w_valid,
               s_b_ready, s_ar_addr, s_ar_valid, s_r_ready,
        input  s_aw_ready, s_w_ready, s_b_resp, s_b_valid,
               s_ar_ready, s_r_data, s_r_resp, s_r_valid
    );

    modport slave (
        input  s_aw_addr, s_aw_valid, s_w_data, s_w_strb, s_w_valid,
               s_b_ready, s_ar_addr, s_ar_valid, s_r_ready,
        output s_aw_ready, s_w_ready, s_b_resp, s_b_valid,
               s_ar_ready, s_r_data, s_r_resp, s_r_valid
    );
endinterface

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - AXI-Lite instruction push window with FWFT FIFO and pop port
// Optional macro INST_QUEUE_OVERFLOW_ERR_EN: full-queue pushes answer SLVERR.
module inst_queue #(
    parameter int ADDR_WIDTH = 64,
    parameter int DEPTH      = 5
) (
    input  logic             aclk,
    input  logic             aresetn,
    inst_queue_if.slave      bus,
    input  logic             pop,
    output logic [31:0]      head,
    output logic             empty,
    output logic             full,
    output logic [DEPTH:0]   count
);
    localparam int ENTRIES = 1 << DEPTH;
    localparam logic [DEPTH:0] FULL_COUNT = {1'b1, {DEPTH{1'b0}}};

    logic [31:0]      mem [ENTRIES];
    logic [DEPTH-1:0] wr_ptr;
    logic [DEPTH-1:0] rd_ptr;
    logic [DEPTH:0]   cnt;

    logic        aw_held;
    logic [1:0]  aw_off_q;
    logic        w_held;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic        b_valid;
    logic [1:0]  b_resp;
    logic        r_valid;
    logic [31:0] r_data;

    logic        aw_hs;
    logic        w_hs;
    logic        ar_hs;
    logic        wr_done;
    logic [1:0]  wr_off;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        push_req;
    logic        push;
    logic        pop_eff;
    logic [1:0]  wr_resp;
    logic [31:0] status_word;
    logic [31:0] rd_value;
    logic        unused_addr_bits;

    assign count = cnt;
    assign empty = (cnt == '0);
    assign full  = (cnt == FULL_COUNT);
    assign head  = empty ? 32'h0 : mem[rd_ptr];

    // Readies are gated by reset so the host sees nothing accepted while held in reset.
    assign bus.s_aw_ready = aresetn && !aw_held && !b_valid;
    assign bus.s_w_ready  = aresetn && !w_held && !b_valid;
    assign bus.s_ar_ready = aresetn && !r_valid;
    assign bus.s_b_valid  = b_valid;
    assign bus.s_b_resp   = b_resp;
    assign bus.s_r_valid  = r_valid;
    assign bus.s_r_data   = r_data;
    assign bus.s_r_resp   = 2'b00;

    assign aw_hs = bus.s_aw_valid && bus.s_aw_ready;
    assign w_hs  = bus.s_w_valid && bus.s_w_ready;
    assign ar_hs = bus.s_ar_valid && bus.s_ar_ready;

    // A write completes once each channel is either already latched or handshaking now.
    assign wr_done = (aw_held || aw_hs) && (w_held || w_hs);
    assign wr_off  = aw_held ? aw_off_q : bus.s_aw_addr[3:2];
    assign wr_data = w_held ? w_data_q : bus.s_w_data;
    assign wr_strb = w_held ? w_strb_q : bus.s_w_strb;

    assign push_req = wr_done && (wr_off == 2'd0) && (wr_strb == 4'hF);
    assign push     = push_req && !full;
    assign pop_eff  = pop && !empty;

`ifdef INST_QUEUE_OVERFLOW_ERR_EN
    assign wr_resp = (push_req && full) ? 2'b10 : 2'b00;
`else
    assign wr_resp = 2'b00;
`endif

    always_comb begin
        status_word       = 32'h0;
        status_word[15:8] = 8'(cnt);
        status_word[1]    = full;
        status_word[0]    = empty;
    end

    always_comb begin
        rd_value = 32'h0;
        case (bus.s_ar_addr[3:2])
            2'd0:    rd_value = head;
            2'd1:    rd_value = status_word;
            default: rd_value = 32'h0;
        endcase
    end

    assign unused_addr_bits = ^{bus.s_aw_addr[ADDR_WIDTH-1:4], bus.s_aw_addr[1:0],
                                bus.s_ar_addr[ADDR_WIDTH-1:4], bus.s_ar_addr[1:0]};

    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop_eff) begin
                cnt <= cnt + 1'b1;
            end else if (pop_eff && !push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            aw_held  <= 1'b0;
            aw_off_q <= 2'd0;
            w_held   <= 1'b0;
            w_data_q <= 32'h0;
            w_strb_q <= 4'h0;
            b_valid  <= 1'b0;
            b_resp   <= 2'b00;
        end else begin
            if (wr_done) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                b_valid <= 1'b1;
                b_resp  <= wr_resp;
            end else begin
                if (aw_hs) begin
                    aw_held  <= 1'b1;
                    aw_off_q <= bus.s_aw_addr[3:2];
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= bus.s_w_data;
                    w_strb_q <= bus.s_w_strb;
                end
                if (b_valid && bus.s_b_ready) begin
                    b_valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_valid <= 1'b0;
            r_data  <= 32'h0;
        end else if (ar_hs) begin
            r_valid <= 1'b1;
            r_data  <= rd_value;
        end else if (r_valid && bus.s_r_ready) begin
            r_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - directed and random checks of inst_queue against a queue model
module tb_inst_queue;
    logic        aclk;
    logic        aresetn;
    logic        pop;
    logic [31:0] head;
    logic        empty;
    logic        full;
    logic [5:0]  count;

    int tests;
    int fails;
    logic [31:0] model_q[$];

    inst_queue_if #(.ADDR_WIDTH(64)) bus ();

    inst_queue #(.ADDR_WIDTH(64), .DEPTH(5)) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .bus(bus),
        .pop(pop),
        .head(head),
        .empty(empty),
        .full(full),
        .count(count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [31:0] exp_head();
        return (model_q.size() == 0) ? 32'h0 : model_q[0];
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = 32'h0;
        s[15:8] = 8'(model_q.size());
        s[1] = (model_q.size() == 32);
        s[0] = (model_q.size() == 0);
        return s;
    endfunction

    function automatic logic [1:0] exp_resp(input logic [1:0] off, input logic [3:0] s);
`ifdef INST_QUEUE_OVERFLOW_ERR_EN
        return (off == 2'd0 && s == 4'hF && model_q.size() == 32) ? 2'b10 : 2'b00;
`else
        return 2'b00;
`endif
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "_count"}, 32'(count), 32'(model_q.size()));
        chk({tag, "_head"}, head, exp_head());
        chk({tag, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
        chk({tag, "_full"}, 32'(full), 32'(model_q.size() == 32));
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] d, input logic [3:0] s,
                      input logic pf);
        logic [63:0] a;
        logic [1:0]  er;
        bit          do_push;
        bit          do_pop;
        a = {$urandom(), $urandom()};
        a[3:2] = off;
        er = exp_resp(off, s);
        do_push = (off == 2'd0) && (s == 4'hF) && (model_q.size() < 32);
        do_pop  = pf && (model_q.size() > 0);
        bus.s_aw_addr = a;
        bus.s_aw_valid = 1'b1;
        bus.s_w_data = d;
        bus.s_w_strb = s;
        bus.s_w_valid = 1'b1;
        pop = pf;
        chk("wr_aw_ready", 32'(bus.s_aw_ready), 32'd1);
        chk("wr_w_ready", 32'(bus.s_w_ready), 32'd1);
        step();
        bus.s_aw_valid = 1'b0;
        bus.s_w_valid = 1'b0;
        pop = 1'b0;
        if (do_pop) void'(model_q.pop_front());
        if (do_push) model_q.push_back(d);
        chk("wr_b_valid", 32'(bus.s_b_valid), 32'd1);
        chk("wr_b_resp", 32'(bus.s_b_resp), 32'(er));
        chk("wr_aw_ready_blocked", 32'(bus.s_aw_ready), 32'd0);
        bus.s_b_ready = 1'b1;
        step();
        bus.s_b_ready = 1'b0;
        chk("wr_b_cleared", 32'(bus.s_b_valid), 32'd0);
    endtask

    task automatic rd(input logic [1:0] off);
        logic [63:0] a;
        logic [31:0] ed;
        a = {$urandom(), $urandom()};
        a[3:2] = off;
        ed = (off == 2'd0) ? exp_head() : (off == 2'd1) ? exp_status() : 32'h0;
        bus.s_ar_addr = a;
        bus.s_ar_valid = 1'b1;
        chk("rd_ar_ready", 32'(bus.s_ar_ready), 32'd1);
        step();
        bus.s_ar_valid = 1'b0;
        chk("rd_r_valid", 32'(bus.s_r_valid), 32'd1);
        chk("rd_r_data", bus.s_r_data, ed);
        chk("rd_r_resp", 32'(bus.s_r_resp), 32'd0);
        chk("rd_ar_ready_blocked", 32'(bus.s_ar_ready), 32'd0);
        bus.s_r_ready = 1'b1;
        step();
        bus.s_r_ready = 1'b0;
        chk("rd_r_cleared", 32'(bus.s_r_valid), 32'd0);
    endtask

    task automatic do_pop();
        pop = 1'b1;
        step();
        pop = 1'b0;
        if (model_q.size() > 0) void'(model_q.pop_front());
    endtask

    initial begin
        tests = 0;
        fails = 0;
        aresetn = 1'b0;
        pop = 1'b0;
        bus.s_aw_addr = '0;
        bus.s_aw_valid = 1'b0;
        bus.s_w_data = '0;
        bus.s_w_strb = '0;
        bus.s_w_valid = 1'b0;
        bus.s_b_ready = 1'b0;
        bus.s_ar_addr = '0;
        bus.s_ar_valid = 1'b0;
        bus.s_r_ready = 1'b0;
        repeat (3) step();

        // Reset state
        check_state("reset");
        chk("reset_aw_ready", 32'(bus.s_aw_ready), 32'd0);
        chk("reset_w_ready", 32'(bus.s_w_ready), 32'd0);
        chk("reset_ar_ready", 32'(bus.s_ar_ready), 32'd0);
        chk("reset_b_valid", 32'(bus.s_b_valid), 32'd0);
        chk("reset_r_valid", 32'(bus.s_r_valid), 32'd0);
        chk("reset_b_resp", 32'(bus.s_b_resp), 32'd0);
        chk("reset_r_data", bus.s_r_data, 32'd0);
        aresetn = 1'b1;
        step();
        chk("rel_aw_ready", 32'(bus.s_aw_ready), 32'd1);
        chk("rel_w_ready", 32'(bus.s_w_ready), 32'd1);
        chk("rel_ar_ready", 32'(bus.s_ar_ready), 32'd1);

        // First push and status read
        wr(2'd0, 32'h0000_0042, 4'hF, 1'b0);
        check_state("first");
        chk("first_head_abs", head, 32'h42);
        rd(2'd1);
        chk("first_status_abs", bus.s_r_data, 32'h0000_0100);
        rd(2'd0);
        do_pop();
        check_state("pop_to_empty");

        // W three cycles ahead of AW
        bus.s_w_data = 32'hCAFE_0001;
        bus.s_w_strb = 4'hF;
        bus.s_w_valid = 1'b1;
        step();
        bus.s_w_valid = 1'b0;
        chk("w_early_w_ready", 32'(bus.s_w_ready), 32'd0);
        chk("w_early_b_valid", 32'(bus.s_b_valid), 32'd0);
        step();
        step();
        check_state("w_early_held");
        bus.s_aw_addr = 64'h0;
        bus.s_aw_valid = 1'b1;
        chk("w_early_aw_ready", 32'(bus.s_aw_ready), 32'd1);
        step();
        bus.s_aw_valid = 1'b0;
        model_q.push_back(32'hCAFE_0001);
        chk("w_early_b_valid_done", 32'(bus.s_b_valid), 32'd1);
        check_state("w_early_push");
        bus.s_b_ready = 1'b1;
        step();
        bus.s_b_ready = 1'b0;
        do_pop();

        // Partial strobe and empty reads
        wr(2'd0, 32'h1111_2222, 4'h7, 1'b0);
        check_state("strb7");
        rd(2'd0);
        wr(2'd2, 32'h3333_4444, 4'hF, 1'b0);
        rd(2'd3);
        check_state("off2");

        // Fill, overflow, drain
        for (int i = 0; i < 32; i++) wr(2'd0, 32'(i), 4'hF, 1'b0);
        check_state("filled");
        chk("filled_full_abs", 32'(full), 32'd1);
        wr(2'd0, 32'h0000_DEAD, 4'hF, 1'b0);
        check_state("overflow");
        rd(2'd1);
        for (int i = 0; i < 32; i++) begin
            chk("drain_head", head, 32'(i));
            do_pop();
        end
        check_state("drained");
        do_pop();
        check_state("pop_empty");

        // Simultaneous push and pop
        wr(2'd0, 32'hA0, 4'hF, 1'b0);
        wr(2'd0, 32'hA1, 4'hF, 1'b0);
        wr(2'd0, 32'hA2, 4'hF, 1'b0);
        wr(2'd0, 32'hA3, 4'hF, 1'b1);
        check_state("pushpop3");
        chk("pushpop3_head_abs", head, 32'hA1);
        repeat (3) do_pop();
        wr(2'd0, 32'hB0, 4'hF, 1'b1);
        check_state("pushpop_empty");
        do_pop();

        // Randomised mix against the model
        for (int it = 0; it < 400; it++) begin
            int unsigned op;
            logic [1:0]  off;
            logic [3:0]  s;
            op  = $urandom_range(0, 9);
            off = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            s   = ($urandom_range(0, 5) == 0) ? 4'($urandom()) : 4'hF;
            if (op < 6) wr(off, $urandom(), s, 1'($urandom_range(0, 3) == 0));
            else if (op < 8) do_pop();
            else rd(2'($urandom_range(0, 3)));
            check_state("rand");
        end

        // Reset in the middle of a pending read
        while (model_q.size() > 0) do_pop();
        for (int i = 0; i < 5; i++) wr(2'd0, 32'h500 + 32'(i), 4'hF, 1'b0);
        bus.s_ar_addr = 64'h0;
        bus.s_ar_valid = 1'b1;
        step();
        bus.s_ar_valid = 1'b0;
        chk("mid_r_valid", 32'(bus.s_r_valid), 32'd1);
        aresetn = 1'b0;
        step();
        model_q.delete();
        check_state("mid_reset");
        chk("mid_reset_r_valid", 32'(bus.s_r_valid), 32'd0);
        chk("mid_reset_ar_ready", 32'(bus.s_ar_ready), 32'd0);
        aresetn = 1'b1;
        step();
        chk("mid_rel_ar_ready", 32'(bus.s_ar_ready), 32'd1);
        check_state("mid_rel");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
